timer_tick_scheduler: RTL
=========================

// Module: timer_tick_scheduler
// PURPOSE
//  Owns the 16-bit Avalon-MM interval-timer slave: programs it at reset exit for a periodic tick,
//  acknowledges each timeout IRQ, and shares the tick among NUM_CH requesters as independent
//  one-shot countdowns. Sits between the timer and the hardware clients that need delays.
// PARAMETERS
//  NUM_CH      4      number of countdown channels (1..16)
//  TICK_PERIOD 50000  clk cycles per tick; timer period programmed as TICK_PERIOD-1 (>=8)
//  DLY_W       16     width of per-channel delay, in ticks
// PORTS
//  clk            in   1               clock
//  reset_n        in   1               async active-low reset
//  tmr_address    out  3               timer slave word address
//  tmr_chipselect out  1               timer chipselect
//  tmr_write_n    out  1               timer write strobe, active-low
//  tmr_writedata  out  16              timer write data
//  tmr_irq        in   1               timer interrupt, level, held until status write
//  req_valid      in   NUM_CH          per-channel start request
//  req_delay      in   NUM_CH*DLY_W    per-channel delay in ticks; ch i at [i*DLY_W +: DLY_W]
//  req_ready      out  NUM_CH          channel idle, request accepted when valid&ready
//  cancel         in   NUM_CH          abort active countdown, no expire
//  busy           out  NUM_CH          countdown in progress
//  expire         out  NUM_CH          1-cycle pulse when countdown completes
//  tick_count     out  32              ticks serviced since reset, wraps at 2^32
//  running        out  1               init sequence complete, ticks being serviced
// BEHAVIOUR
//  Reset: clk and reset_n as decided (reset_n async active-low, clock clk). On reset:
//   tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0,
//   busy=0, expire=0, tick_count=0, running=0, state=INIT_STOP. All outputs registered except req_ready.
//  Bus: each write is one cycle, chipselect=1, write_n=0; no wait states; idle cycles drive cs=0, wn=1.
//  FSM (one state per cycle unless noted):
//   INIT_STOP  write addr1 = 0x0008 (stop)                   -> WR_PL
//   WR_PL      write addr2 = (TICK_PERIOD-1)[15:0]           -> WR_PH
//   WR_PH      write addr3 = (TICK_PERIOD-1)[31:16]          -> WR_CTRL
//   WR_CTRL    write addr1 = 0x0007 (START|CONT|ITO)         -> IDLE, running<=1
//   IDLE       no access; stays until tmr_irq=1              -> CLR
//   CLR        write addr0 = 0x0000 (clear timeout)          -> SERVICE
//   SERVICE    tick_count+1; advance channels                -> IDLE
//  tmr_irq ignored outside IDLE; an IRQ pending on entry to IDLE is taken next cycle.
//  SERVICE always lasts exactly one cycle; the IRQ is low again by then.
//  Channel i (all channels advance in parallel):
//   req_ready[i] = ~busy[i] (combinational). Accept: load cnt = max(req_delay,1), busy<=1.
//   SERVICE: if busy & ~cancel: cnt==1 -> busy<=0, expire<=1 next cycle; else cnt-1.
//   Delay D expires on the D-th SERVICE strictly after the accept cycle. A SERVICE cycle that
//    coincides with the accept cycle does not count. D=0 behaves as D=1.
//   cancel[i] while busy: busy<=0, cnt unchanged, no expire; cancel beats a same-cycle expiry.
//   cancel while idle: no effect, and it blocks a same-cycle accept (req_ready stays 1).
//   Requests accepted in any state, including before running=1. Countdowns only advance
//    once ticks are serviced.
//  Reset mid-operation: all countdowns dropped silently (no expire); init sequence replays in full.
// TESTING
//  T1 TICK_PERIOD=50000, release reset -> writes (1,0x0008),(2,0xC34F),(3,0x0000),(1,0x0007) in
//     4 consecutive cycles; running=1 the following cycle.
//  T2 raise tmr_irq in IDLE -> next cycle write (0,0x0000); cycle after, tick_count 0->1;
//     no further access until the next irq.
//  T3 ch0 req delay=3 -> busy[0]=1; expire[0] one-cycle pulse the cycle after the 3rd SERVICE;
//     busy[0]=0.
//  T4 ch1 delay=0 and ch2 delay=1 accepted same cycle -> both expire on 1st tick together;
//     ch3 delay=2 expires 1 tick later.
//  T5 ch0 delay=2, assert cancel[0] in the SERVICE cycle where cnt==1 -> no expire, busy[0]=0,
//     req_ready[0]=1.
//  T6 reset_n pulsed low with ch0-3 busy -> all outputs reset values, no expire, T1 sequence repeats.

Source files
------------

// File: rtl/timer_tick_scheduler.sv
// Programs the interval timer for a periodic tick, acknowledges each timeout IRQ,
// and advances NUM_CH independent one-shot tick countdowns on every serviced tick.
module timer_tick_scheduler #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned TICK_PERIOD = 50000,
    parameter int unsigned DLY_W       = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    output logic [2:0]                tmr_address,
    output logic                      tmr_chipselect,
    output logic                      tmr_write_n,
    output logic [15:0]               tmr_writedata,
    input  logic                      tmr_irq,
    input  logic [NUM_CH-1:0]         req_valid,
    input  logic [NUM_CH*DLY_W-1:0]   req_delay,
    output logic [NUM_CH-1:0]         req_ready,
    input  logic [NUM_CH-1:0]         cancel,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         expire,
    output logic [31:0]               tick_count,
    output logic                      running
);

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 16;
    localparam int unsigned TW = 32;
    localparam logic [TW-1:0] PERIOD_M1 = TW'(TICK_PERIOD - 1);

    typedef enum logic [2:0] {
        INIT_STOP, WR_PL, WR_PH, WR_CTRL, IDLE, CLR, SERVICE
    } state_e;

    state_e            state_q, state_d;
    logic              cs_q, cs_d;
    logic              wn_q, wn_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     data_q, data_d;
    logic              running_q, running_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [NUM_CH-1:0] busy_q, busy_d;
    logic [NUM_CH-1:0] expire_q, expire_d;
    logic [DLY_W-1:0]  cnt_q [NUM_CH];
    logic [DLY_W-1:0]  cnt_d [NUM_CH];
    logic              svc_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= INIT_STOP;
            cs_q      <= 1'b0;
            wn_q      <= 1'b1;
            addr_q    <= '0;
            data_q    <= '0;
            running_q <= 1'b0;
            tick_q    <= '0;
            busy_q    <= '0;
            expire_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cs_q      <= cs_d;
            wn_q      <= wn_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            running_q <= running_d;
            tick_q    <= tick_d;
            busy_q    <= busy_d;
            expire_q  <= expire_d;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Init writes, then wait for IRQ -> clear status -> service one tick.
    always_comb begin
        state_d   = state_q;
        cs_d      = 1'b0;
        wn_d      = 1'b1;
        addr_d    = '0;
        data_d    = '0;
        running_d = running_q;
        tick_d    = tick_q;
        case (state_q)
            INIT_STOP: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = AW'(1); data_d = DW'(16'h0008);
                state_d = WR_PL;
            end
            WR_PL: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = AW'(2); data_d = PERIOD_M1[15:0];
                state_d = WR_PH;
            end
            WR_PH: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = AW'(3); data_d = PERIOD_M1[31:16];
                state_d = WR_CTRL;
            end
            WR_CTRL: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = AW'(1); data_d = DW'(16'h0007);
                running_d = 1'b1;
                state_d   = IDLE;
            end
            IDLE: begin
                if (tmr_irq) state_d = CLR;
            end
            CLR: begin
                cs_d = 1'b1; wn_d = 1'b0; addr_d = AW'(0); data_d = DW'(16'h0000);
                state_d = SERVICE;
            end
            SERVICE: begin
                tick_d  = tick_q + TW'(1);
                state_d = IDLE;
            end
            default: state_d = INIT_STOP;
        endcase
    end

    assign svc_c = (state_q == SERVICE);

    // Per-channel countdown; cancel wins over both expiry and a same-cycle accept.
    always_comb begin
        logic [DLY_W-1:0] dly;
        dly      = '0;
        busy_d   = busy_q;
        expire_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            dly      = req_delay[i*DLY_W +: DLY_W];
            if (busy_q[i]) begin
                if (cancel[i]) begin
                    busy_d[i] = 1'b0;
                end else if (svc_c) begin
                    if (cnt_q[i] == DLY_W'(1)) begin
                        busy_d[i]   = 1'b0;
                        expire_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] - DLY_W'(1);
                    end
                end
            end else if (req_valid[i] && !cancel[i]) begin
                busy_d[i] = 1'b1;
                cnt_d[i]  = (dly == '0) ? DLY_W'(1) : dly;
            end
        end
    end

    assign tmr_address    = addr_q;
    assign tmr_chipselect = cs_q;
    assign tmr_write_n    = wn_q;
    assign tmr_writedata  = data_q;
    assign req_ready      = ~busy_q;
    assign busy           = busy_q;
    assign expire         = expire_q;
    assign tick_count     = tick_q;
    assign running        = running_q;

endmodule
